// File: rtl/display_pkg.sv
// Shared types and constants for the display path (binary -> BCD -> 7-segment).
package display_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bin2bcd_state_t;

    localparam int         DISP_DIGITS    = 8;
    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;

    // True when d decimal digits can hold every w-bit unsigned value,
    // i.e. 10^d >= 2^w. Valid for w < 256 and d <= 77.
    function automatic bit bcd_digits_ok(input int w, input int d);
        logic [255:0] pow10;
        logic [255:0] lim;
        pow10 = 256'd1;
        lim   = 256'd1 << w;
        for (int i = 0; i < d; i++) begin
            pow10 = pow10 * 256'd10;
        end
        return pow10 >= lim;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a digit of 5..9 gets +3 so the following
// left shift carries into the next decimal digit.
module bcd_digit_adjust
    import display_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    // 4-bit add, carry out discarded (cannot occur for legal digits 0..9)
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_ADJ_THRESH) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to packed BCD converter, one bit per clock.
// Optional leading-zero blanking output enabled with macro BIN2BCD_LZB_EN.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
`ifdef BIN2BCD_LZB_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    // The top digit must never overflow: 10^DIGITS has to exceed 2^WIDTH - 1
    if (!bcd_digits_ok(WIDTH, DIGITS)) begin : g_param_chk
        $error("bin2bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
    end

    bin2bcd_state_t                       state_q, state_d;
    logic [WIDTH-1:0]                     shift_q, shift_d;
    logic [DIGITS-1:0][3:0]               scratch_q, scratch_d;
    logic [DIGITS-1:0][3:0]               adj;
    logic [CW-1:0]                        cnt_q, cnt_d;
    logic                                 done_q, done_d;
    logic [4*DIGITS-1:0]                  bcd_q, bcd_d;
    logic [4*DIGITS+WIDTH-1:0]            shifted;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (scratch_q[g]),
            .digit_o (adj[g])
        );
    end

    // Adjusted digits and remaining binary bits move left as one register
    assign shifted = {adj, shift_q} << 1;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted[4*DIGITS+WIDTH-1:WIDTH];
                shift_d   = shifted[WIDTH-1:0];
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Result and done pulse land on the edge leaving DONE
                bcd_d   = scratch_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign bcd  = bcd_q;

`ifdef BIN2BCD_LZB_EN
    logic [DIGITS-1:0] blank_q, blank_d;

    // Blank a digit when it and every higher digit are zero; ones never blank
    always_comb begin
        blank_d = '0;
        blank_d[DIGITS-1] = (scratch_q[DIGITS-1] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            blank_d[i] = blank_d[i+1] && (scratch_q[i] == 4'd0);
        end
        blank_d[0] = 1'b0;
    end

    // Blank mask registered alongside bcd
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= ~DIGITS'(1);
        end else if (state_q == DONE) begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes hand-computed BCD results,
// a monitor pops and compares on every done pulse.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] bin;
    logic        busy;
    logic        done;
    logic [39:0] bcd;
`ifdef BIN2BCD_LZB_EN
    logic [9:0]  blank;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;

    logic [39:0] exp_q[$];
    logic [9:0]  expb_q[$];

    bin2bcd_seq #(.WIDTH(32), .DIGITS(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
`ifdef BIN2BCD_LZB_EN
        ,
        .blank (blank)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [39:0] e;
                logic [9:0]  eb;
                e  = exp_q.pop_front();
                eb = expb_q.pop_front();
                chk("bcd", {24'd0, bcd}, {24'd0, e});
`ifdef BIN2BCD_LZB_EN
                chk("blank", {54'd0, blank}, {54'd0, eb});
`else
                if (eb === 10'bx) chk("blank_exp", 64'd0, 64'd1);
`endif
            end
        end
    end

    // Wait (bounded) for done, sampling #1 after each edge
    task automatic wait_done(output int lat, output int bsy);
        lat = 0;
        bsy = 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bsy++;
        end
        if (!done) chk("done_timeout", 64'd0, 64'd1);
    endtask

    // Issue one conversion and check latency and busy length
    task automatic run(input string name, input logic [31:0] v,
                       input logic [39:0] e, input logic [9:0] eb);
        int lat, bsy;
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        exp_q.push_back(e);
        expb_q.push_back(eb);
        @(posedge clk); #1;
        start = 1'b0;
        bin   = 32'hDEAD_BEEF;        // must not affect the conversion
        wait_done(lat, bsy);
        bsy += 1;                      // cycle right after the accepting edge
        chk({name, "_latency"}, 64'(lat), 64'd33);
        chk({name, "_busy_cycles"}, 64'(bsy), 64'd33);
    endtask

    initial begin
        int lat, bsy;
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_bcd",  {24'd0, bcd},  64'd0);
`ifdef BIN2BCD_LZB_EN
        chk("rst_blank", {54'd0, blank}, 64'h3FE);
`endif
        rst_n = 1'b1;

        run("zero",  32'd0,          40'h00_0000_0000, 10'b1111111110);
        run("d1234", 32'd1234,       40'h00_0000_1234, 10'b1111110000);
        run("max",   32'hFFFF_FFFF,  40'h42_9496_7295, 10'b0000000000);
        run("d305",  32'd305,        40'h00_0000_0305, 10'b1111111000);

        // Start while busy is ignored; start held through DONE is accepted
        // on the first IDLE edge afterwards
        @(negedge clk);
        bin = 32'd99; start = 1'b1;
        exp_q.push_back(40'h99); expb_q.push_back(10'b1111111100);
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; bin = 32'd55;   // ignored pulse mid-SHIFT
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; bin = 32'd7;    // held high through DONE
        exp_q.push_back(40'h7); expb_q.push_back(10'b1111111110);
        wait_done(lat, bsy);
        chk("held_first_busy_low", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0; bin = 32'd123;
        chk("held_accepted_busy", {63'd0, busy}, 64'd1);
        repeat (10) @(posedge clk); #1;
        chk("bcd_held_mid_conv", {24'd0, bcd}, 64'h99);
        wait_done(lat, bsy);
        chk("held_second_latency", 64'(lat), 64'd23);

        // Reset mid-conversion aborts with no done pulse
        @(negedge clk);
        bin = 32'd500; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_bcd",  {24'd0, bcd},  64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);    // monitor flags any stray done
        run("d42", 32'd42, 40'h42, 10'b1111111100);

        repeat (3) @(negedge clk);
        chk("done_count", 64'(n_done), 64'd7);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
